// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: full-duplex UART with a runtime bit-period divider, optional
// parity and show-ahead TX/RX FIFOs on ready/valid interfaces.
module uart_fifo_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIV_W-1:0]            i_div,
  input  logic                        i_par_en,
  input  logic                        i_par_odd,
  input  logic                        i_tx_valid,
  output logic                        o_tx_ready,
  input  logic [DATA_BITS-1:0]        i_tx_data,
  output logic                        o_rx_valid,
  input  logic                        i_rx_ready,
  output logic [DATA_BITS-1:0]        o_rx_data,
  output logic [$clog2(FIFO_DEPTH):0] o_tx_level,
  output logic [$clog2(FIFO_DEPTH):0] o_rx_level,
  output logic                        o_tx_busy,
  output logic                        o_err_frame,
  output logic                        o_err_parity,
  output logic                        o_err_overrun,
  input  logic                        i_uart_rx,
  output logic                        o_uart_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // Divider clamped to the shortest usable bit period.
  logic [DIV_W-1:0] div_clamped;
  assign div_clamped = (i_div < DIV_W'(4)) ? DIV_W'(4) : i_div;

  // FIFO state
  logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [LW-1:0] tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic          tx_push, tx_pop, rx_push, rx_pop;

  // TX FSM state
  state_e               tx_state_q, tx_state_d;
  logic [DIV_W-1:0]     tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, tx_head;
  logic tx_pen_q, tx_pen_d, tx_par_q, tx_par_d, tx_out_q, tx_out_d, tx_start;

  // RX FSM state
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  state_e               rx_state_q, rx_state_d;
  logic [DIV_W-1:0]     rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d, rx_pbad_q, rx_pbad_d;
  logic err_frame_q, err_frame_d, err_parity_q, err_parity_d;
  logic err_overrun_q, err_overrun_d;

  assign o_tx_ready    = (tx_level_q != FULL);
  assign tx_push       = i_tx_valid && o_tx_ready;
  assign tx_pop        = tx_start;
  assign tx_head       = tx_mem_q[tx_rd_q];
  assign o_tx_level    = tx_level_q;
  assign o_rx_valid    = (rx_level_q != '0);
  assign rx_pop        = o_rx_valid && i_rx_ready;
  assign o_rx_data     = rx_mem_q[rx_rd_q];
  assign o_rx_level    = rx_level_q;
  assign o_tx_busy     = (tx_state_q != S_IDLE);
  assign o_uart_tx     = tx_out_q;
  assign o_err_frame   = err_frame_q;
  assign o_err_parity  = err_parity_q;
  assign o_err_overrun = err_overrun_q;

  // Pointer and level bookkeeping for both FIFOs; pointers wrap naturally.
  // NOTE: every signal written here is assigned on every path, so no latch is inferred.
  always_comb begin
    tx_wr_d    = tx_wr_q + AW'(tx_push);
    tx_rd_d    = tx_rd_q + AW'(tx_pop);
    tx_level_d = tx_level_q + LW'(tx_push) - LW'(tx_pop);
    rx_wr_d    = rx_wr_q + AW'(rx_push);
    rx_rd_d    = rx_rd_q + AW'(rx_pop);
    rx_level_d = rx_level_q + LW'(rx_push) - LW'(rx_pop);
  end

  // FIFO pointer and level registers.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_q <= '0; tx_rd_q <= '0; tx_level_q <= '0;
      rx_wr_q <= '0; rx_rd_q <= '0; rx_level_q <= '0;
    end else begin
      tx_wr_q <= tx_wr_d; tx_rd_q <= tx_rd_d; tx_level_q <= tx_level_d;
      rx_wr_q <= rx_wr_d; rx_rd_q <= rx_rd_d; rx_level_q <= rx_level_d;
    end
  end

  // TX storage: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= i_tx_data;
  end

  // RX storage; the head drives o_rx_data directly.
  // NOTE: this array is reset because its head is visible at the port; TX storage is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem_q[i] <= '0;
    end else if (rx_push) begin
      rx_mem_q[rx_wr_q] <= rx_sh_q;
    end
  end

  // TX framing: each bit held div cycles; back-to-back frames restart from STOP.
  always_comb begin
    tx_state_d = tx_state_q; tx_cnt_d = tx_cnt_q; tx_div_d = tx_div_q;
    tx_bit_d   = tx_bit_q;   tx_sh_d  = tx_sh_q;  tx_pen_d = tx_pen_q;
    tx_par_d   = tx_par_q;   tx_out_d = tx_out_q; tx_start = 1'b0;
    if (tx_state_q != S_IDLE && tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - DIV_W'(1);
    case (tx_state_q)
      S_IDLE:  tx_start = (tx_level_q != '0);
      S_START: if (tx_cnt_q == '0) begin
        tx_state_d = S_DATA;
        tx_bit_d   = '0;
        tx_out_d   = tx_sh_q[0];
        tx_sh_d    = tx_sh_q >> 1;
        tx_cnt_d   = tx_div_q - DIV_W'(1);
      end
      S_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = tx_div_q - DIV_W'(1);
        if (tx_bit_q == LAST_BIT) begin
          tx_state_d = tx_pen_q ? S_PARITY : S_STOP;
          tx_out_d   = tx_pen_q ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + BW'(1);
          tx_out_d = tx_sh_q[0];
          tx_sh_d  = tx_sh_q >> 1;
        end
      end
      S_PARITY: if (tx_cnt_q == '0) begin
        tx_state_d = S_STOP;
        tx_out_d   = 1'b1;
        tx_cnt_d   = tx_div_q - DIV_W'(1);
      end
      S_STOP: if (tx_cnt_q == '0) begin
        if (tx_level_q != '0) tx_start = 1'b1;
        else tx_state_d = S_IDLE;
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_start) begin
      tx_state_d = S_START;
      tx_out_d   = 1'b0;
      tx_sh_d    = tx_head;
      tx_div_d   = div_clamped;
      tx_pen_d   = i_par_en;
      tx_par_d   = (^tx_head) ^ i_par_odd;
      tx_cnt_d   = div_clamped - DIV_W'(1);
    end
  end

  // TX FSM registers; the line idles high, including asynchronously in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE; tx_cnt_q <= '0; tx_div_q <= DIV_W'(4);
      tx_bit_q   <= '0;     tx_sh_q  <= '0; tx_pen_q <= 1'b0;
      tx_par_q   <= 1'b0;   tx_out_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_div_q <= tx_div_d;
      tx_bit_q   <= tx_bit_d;   tx_sh_q  <= tx_sh_d;  tx_pen_q <= tx_pen_d;
      tx_par_q   <= tx_par_d;   tx_out_q <= tx_out_d;
    end
  end

  // RX framing: start sampled at mid-bit, later bits every div cycles.
  always_comb begin
    rx_state_d = rx_state_q; rx_cnt_d = rx_cnt_q; rx_div_d = rx_div_q;
    rx_bit_d   = rx_bit_q;   rx_sh_d  = rx_sh_q;  rx_pen_d = rx_pen_q;
    rx_odd_d   = rx_odd_q;   rx_pbad_d = rx_pbad_q;
    rx_push = 1'b0; err_frame_d = 1'b0; err_parity_d = 1'b0; err_overrun_d = 1'b0;
    if (rx_state_q != S_IDLE && rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - DIV_W'(1);
    case (rx_state_q)
      S_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = S_START;
        rx_div_d   = div_clamped;
        rx_pen_d   = i_par_en;
        rx_odd_d   = i_par_odd;
        rx_pbad_d  = 1'b0;
        rx_cnt_d   = (div_clamped >> 1) - DIV_W'(1);
      end
      S_START: if (rx_cnt_q == '0) begin
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        rx_bit_d   = '0;
        rx_cnt_d   = rx_div_q - DIV_W'(1);
      end
      S_DATA: if (rx_cnt_q == '0) begin
        rx_cnt_d = rx_div_q - DIV_W'(1);
        rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
        if (rx_bit_q == LAST_BIT) rx_state_d = rx_pen_q ? S_PARITY : S_STOP;
        else rx_bit_d = rx_bit_q + BW'(1);
      end
      S_PARITY: if (rx_cnt_q == '0) begin
        rx_state_d = S_STOP;
        rx_pbad_d  = rx_s2_q != ((^rx_sh_q) ^ rx_odd_q);
        rx_cnt_d   = rx_div_q - DIV_W'(1);
      end
      S_STOP: if (rx_cnt_q == '0) begin
        rx_state_d = S_IDLE;
        if (!rx_s2_q)                  err_frame_d   = 1'b1;
        else if (rx_pen_q && rx_pbad_q) err_parity_d  = 1'b1;
        else if (rx_level_q == FULL)    err_overrun_d = 1'b1;
        else                            rx_push       = 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // RX synchroniser, FSM registers and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      rx_state_q <= S_IDLE; rx_cnt_q <= '0; rx_div_q <= DIV_W'(4);
      rx_bit_q <= '0; rx_sh_q <= '0; rx_pen_q <= 1'b0; rx_odd_q <= 1'b0;
      rx_pbad_q <= 1'b0; err_frame_q <= 1'b0; err_parity_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      rx_s1_q <= i_uart_rx; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
      rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_div_q <= rx_div_d;
      rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d; rx_pen_q <= rx_pen_d;
      rx_odd_q <= rx_odd_d; rx_pbad_q <= rx_pbad_d;
      err_frame_q <= err_frame_d; err_parity_q <= err_parity_d;
      err_overrun_q <= err_overrun_d;
    end
  end

endmodule
